// File: rtl/fixed_linear_rq.sv
// rtl/fixed_linear_rq.sv - parallel fixed-point dot-product layer with bias, ReLU and round/saturate requantisation
module fixed_linear_rq #(
    parameter int IN_WIDTH          = 8,
    parameter int IN_FRAC_WIDTH     = 4,
    parameter int IN_SIZE           = 4,
    parameter int IN_DEPTH          = 3,
    parameter int PARALLELISM       = 2,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int WEIGHT_FRAC_WIDTH = 4,
    parameter int HAS_BIAS          = 1,
    parameter int BIAS_WIDTH        = 8,
    parameter int BIAS_FRAC_WIDTH   = 4,
    parameter int OUT_WIDTH         = 8,
    parameter int OUT_FRAC_WIDTH    = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [IN_WIDTH*IN_SIZE-1:0]               i_data_in,
    input  logic                                      i_data_in_valid,
    output logic                                      o_data_in_ready,
    input  logic [WEIGHT_WIDTH*IN_SIZE*PARALLELISM-1:0] i_weight,
    input  logic                                      i_weight_valid,
    output logic                                      o_weight_ready,
    input  logic [BIAS_WIDTH*PARALLELISM-1:0]         i_bias,
    input  logic                                      i_bias_valid,
    output logic                                      o_bias_ready,
    input  logic                                      i_relu_en,
    output logic [OUT_WIDTH*PARALLELISM-1:0]          o_data_out,
    output logic [PARALLELISM-1:0]                    o_data_out_sat,
    output logic                                      o_data_out_valid,
    input  logic                                      i_data_out_ready
);
    localparam int DOT_W = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE);
    localparam int ACC_W = DOT_W + $clog2(IN_DEPTH) + 1;
    localparam int FA    = IN_FRAC_WIDTH + WEIGHT_FRAC_WIDTH;
    localparam int B_SHL = (FA >= BIAS_FRAC_WIDTH) ? FA - BIAS_FRAC_WIDTH : 0;
    localparam int B_SHR = (BIAS_FRAC_WIDTH > FA) ? BIAS_FRAC_WIDTH - FA : 0;
    localparam int R_SHR = (FA > OUT_FRAC_WIDTH) ? FA - OUT_FRAC_WIDTH : 0;
    localparam int R_SHL = (OUT_FRAC_WIDTH > FA) ? OUT_FRAC_WIDTH - FA : 0;
    localparam int RQ_W  = ACC_W + 1 + R_SHL;
    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    // Half an output LSB; zero when no right shift is needed
    localparam logic signed [RQ_W-1:0] RND  = RQ_W'((64'(1) << R_SHR) >> 1);
    localparam logic signed [RQ_W-1:0] OMAX = RQ_W'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
    localparam logic signed [RQ_W-1:0] OMIN = -OMAX - RQ_W'(1);

    typedef enum logic [1:0] {S_ACC, S_BIAS, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_relu;
    logic signed [ACC_W-1:0]  r_acc     [PARALLELISM];
    logic signed [DOT_W-1:0]  w_dot     [PARALLELISM];
    logic signed [ACC_W-1:0]  w_bias_al [PARALLELISM];
    logic signed [RQ_W-1:0]   w_rq      [PARALLELISM];
    logic [OUT_WIDTH*PARALLELISM-1:0] w_q;
    logic [PARALLELISM-1:0]   w_sat;
    logic                     w_beat, w_last, w_bias_fire, w_out_load;

    assign o_data_in_ready = i_weight_valid & (r_state == S_ACC);
    assign o_weight_ready  = i_data_in_valid & (r_state == S_ACC);
    assign o_bias_ready    = (HAS_BIAS != 0) ? (r_state == S_BIAS) : 1'b1;
    assign w_beat      = i_data_in_valid & i_weight_valid & (r_state == S_ACC);
    assign w_last      = (r_cnt == CNT_W'(IN_DEPTH - 1));
    assign w_bias_fire = (HAS_BIAS != 0) & (r_state == S_BIAS) & i_bias_valid;
    assign w_out_load  = (r_state == S_DONE) & (~o_data_out_valid | i_data_out_ready);

    always_comb begin
        for (int p = 0; p < PARALLELISM; p++) begin
            w_dot[p] = '0;
            for (int i = 0; i < IN_SIZE; i++) begin
                w_dot[p] = w_dot[p]
                    + DOT_W'($signed(i_data_in[i*IN_WIDTH +: IN_WIDTH]))
                    * DOT_W'($signed(i_weight[(IN_SIZE*p + i)*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            end
            w_bias_al[p] = (ACC_W'($signed(i_bias[p*BIAS_WIDTH +: BIAS_WIDTH])) <<< B_SHL) >>> B_SHR;
        end
    end

    // Round half toward +inf, then ReLU, then clamp; ReLU zeroing never flags saturation
    always_comb begin
        w_q   = '0;
        w_sat = '0;
        for (int p = 0; p < PARALLELISM; p++) begin
            w_rq[p] = ((RQ_W'(r_acc[p]) + RND) >>> R_SHR) <<< R_SHL;
            if (r_relu && (w_rq[p] < 0)) begin
                w_rq[p] = '0;
            end
            if (w_rq[p] > OMAX) begin
                w_q[p*OUT_WIDTH +: OUT_WIDTH] = OMAX[OUT_WIDTH-1:0];
                w_sat[p] = 1'b1;
            end else if (w_rq[p] < OMIN) begin
                w_q[p*OUT_WIDTH +: OUT_WIDTH] = OMIN[OUT_WIDTH-1:0];
                w_sat[p] = 1'b1;
            end else begin
                w_q[p*OUT_WIDTH +: OUT_WIDTH] = w_rq[p][OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ACC:   if (w_beat && w_last) w_next = (HAS_BIAS != 0) ? S_BIAS : S_DONE;
            S_BIAS:  if (w_bias_fire) w_next = S_DONE;
            S_DONE:  if (w_out_load) w_next = S_ACC;
            default: w_next = S_ACC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_ACC;
            r_cnt   <= '0;
            r_relu  <= 1'b0;
            for (int p = 0; p < PARALLELISM; p++) r_acc[p] <= '0;
        end else begin
            r_state <= w_next;
            if (w_beat) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                if (r_cnt == '0) r_relu <= i_relu_en;
                for (int p = 0; p < PARALLELISM; p++) begin
                    if (r_cnt == '0) r_acc[p] <= ACC_W'(w_dot[p]);
                    else             r_acc[p] <= r_acc[p] + ACC_W'(w_dot[p]);
                end
            end else if (w_bias_fire) begin
                for (int p = 0; p < PARALLELISM; p++) r_acc[p] <= r_acc[p] + w_bias_al[p];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data_out       <= '0;
            o_data_out_sat   <= '0;
            o_data_out_valid <= 1'b0;
        end else if (w_out_load) begin
            o_data_out       <= w_q;
            o_data_out_sat   <= w_sat;
            o_data_out_valid <= 1'b1;
        end else if (o_data_out_valid && i_data_out_ready) begin
            o_data_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fixed_linear_rq.sv
// tb/tb_fixed_linear_rq.sv - directed self-checking bench for fixed_linear_rq
module tb_fixed_linear_rq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [63:0] weight;
    logic        weight_valid;
    logic        weight_ready;
    logic [15:0] bias;
    logic        bias_valid;
    logic        bias_ready;
    logic        relu_en;
    logic [15:0] data_out;
    logic [1:0]  data_out_sat;
    logic        data_out_valid;
    logic        data_out_ready;

    int checks   = 0;
    int failures = 0;

    fixed_linear_rq dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_data_in        (data_in),
        .i_data_in_valid  (data_in_valid),
        .o_data_in_ready  (data_in_ready),
        .i_weight         (weight),
        .i_weight_valid   (weight_valid),
        .o_weight_ready   (weight_ready),
        .i_bias           (bias),
        .i_bias_valid     (bias_valid),
        .o_bias_ready     (bias_ready),
        .i_relu_en        (relu_en),
        .o_data_out       (data_out),
        .o_data_out_sat   (data_out_sat),
        .o_data_out_valid (data_out_valid),
        .i_data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [31:0] w0, input logic [31:0] w1,
                             input logic relu);
        int n = 0;
        data_in = d; weight = {w1, w0}; relu_en = relu;
        data_in_valid = 1'b1; weight_valid = 1'b1;
        #1;
        while (!(data_in_ready && weight_ready) && n < 40) begin
            tick();
            n++;
        end
        check("beat_accept", (n < 40), 1'b1);
        tick();
        data_in_valid = 1'b0; weight_valid = 1'b0; relu_en = 1'b0;
        data_in = '0; weight = '0;
    endtask

    task automatic send_bias(input logic [7:0] b0, input logic [7:0] b1);
        int n = 0;
        bias = {b1, b0}; bias_valid = 1'b1;
        #1;
        while (!bias_ready && n < 40) begin
            tick();
            n++;
        end
        check("bias_accept", (n < 40), 1'b1);
        tick();
        bias_valid = 1'b0; bias = '0;
    endtask

    task automatic run_block(input logic [7:0] d, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] b, input logic relu0, input logic relu1);
        send_beat({4{d}}, {4{w0}}, {4{w1}}, relu0);
        send_beat({4{d}}, {4{w0}}, {4{w1}}, relu1);
        send_beat({4{d}}, {4{w0}}, {4{w1}}, 1'b0);
        send_bias(b, b);
    endtask

    task automatic check_out(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                             input logic [1:0] sat);
        check({tag, "_valid"}, data_out_valid, 1'b1);
        check({tag, "_lane0"}, data_out[7:0], l0);
        check({tag, "_lane1"}, data_out[15:8], l1);
        check({tag, "_sat"}, data_out_sat, sat);
    endtask

    initial begin
        rst_n = 1'b0;
        data_in = '0; data_in_valid = 1'b0; weight = '0; weight_valid = 1'b0;
        bias = '0; bias_valid = 1'b0; relu_en = 1'b0; data_out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_data", data_out, 16'h0000);
        check("rst_sat", data_out_sat, 2'b00);
        check("rst_bias_ready", bias_ready, 1'b0);
        check("rst_din_ready_idle", data_in_ready, 1'b0);
        weight_valid = 1'b1;
        #1;
        check("rst_din_ready", data_in_ready, 1'b1);
        weight_valid = 1'b0;
        rst_n = 1'b1;
        data_out_ready = 1'b1;
        tick();

        // Test 1: 6.0+1.0 and -3.0+1.0, valid two cycles after bias
        run_block(8'h10, 8'h08, 8'hFC, 8'h10, 1'b0, 1'b0);
        check("t1_valid_early", data_out_valid, 1'b0);
        tick();
        check_out("t1", 8'h70, 8'hE0, 2'b00);
        tick();
        check("t1_valid_drop", data_out_valid, 1'b0);

        // Test 2: saturation both directions
        run_block(8'h7F, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0);
        tick();
        check_out("t2", 8'h7F, 8'h80, 2'b11);
        tick();

        // Test 3: rounding half toward +inf
        send_beat(32'h0000_0001, 32'h0000_0008, 32'h0, 1'b0);
        send_beat(32'h0, 32'h0, 32'h0, 1'b0);
        send_beat(32'h0, 32'h0, 32'h0, 1'b0);
        send_bias(8'h00, 8'h00);
        tick();
        check_out("t3a", 8'h01, 8'h00, 2'b00);
        tick();
        send_beat(32'h0000_0001, 32'h0000_00F8, 32'h0, 1'b0);
        send_beat(32'h0, 32'h0, 32'h0, 1'b0);
        send_beat(32'h0, 32'h0, 32'h0, 1'b0);
        send_bias(8'h00, 8'h00);
        tick();
        check_out("t3b", 8'h00, 8'h00, 2'b00);
        tick();

        // Test 4: ReLU latched only on the first beat
        run_block(8'h10, 8'h08, 8'hFC, 8'h10, 1'b1, 1'b0);
        tick();
        check_out("t4a", 8'h70, 8'h00, 2'b00);
        tick();
        run_block(8'h10, 8'h08, 8'hFC, 8'h10, 1'b0, 1'b1);
        tick();
        check_out("t4b", 8'h70, 8'hE0, 2'b00);
        tick();

        // Test 5: back-to-back with downstream stalled
        data_out_ready = 1'b0;
        run_block(8'h10, 8'h08, 8'hFC, 8'h10, 1'b0, 1'b0);
        tick();
        check_out("t5_a", 8'h70, 8'hE0, 2'b00);
        run_block(8'h7F, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        check_out("t5_a_held", 8'h70, 8'hE0, 2'b00);
        data_in_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
        #1;
        check("t5_stall_din_ready", data_in_ready, 1'b0);
        check("t5_stall_w_ready", weight_ready, 1'b0);
        check("t5_stall_b_ready", bias_ready, 1'b0);
        data_in_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
        data_out_ready = 1'b1;
        tick();
        check_out("t5_b", 8'h7F, 8'h80, 2'b11);
        tick();
        check("t5_drain", data_out_valid, 1'b0);

        // Test 6: reset mid-block clears outputs immediately and leaves no residue
        data_out_ready = 1'b0;
        run_block(8'h10, 8'h08, 8'hFC, 8'h10, 1'b0, 1'b0);
        tick();
        check("t6_pre_valid", data_out_valid, 1'b1);
        send_beat({4{8'h7F}}, {4{8'h7F}}, {4{8'h80}}, 1'b1);
        send_beat({4{8'h7F}}, {4{8'h7F}}, {4{8'h80}}, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", data_out_valid, 1'b0);
        check("t6_rst_data", data_out, 16'h0000);
        check("t6_rst_sat", data_out_sat, 2'b00);
        tick(); tick();
        rst_n = 1'b1;
        data_out_ready = 1'b1;
        tick();
        run_block(8'h10, 8'h08, 8'hFC, 8'h10, 1'b0, 1'b0);
        tick();
        check_out("t6_rerun", 8'h70, 8'hE0, 2'b00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
